// File: rtl/fifo_frame_pkg.sv
// rtl/fifo_frame_pkg.sv - shared types and trailer helpers for the frame writer/reader pair
package fifo_frame_pkg;

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    T_CNT   = 2'd1,
    T_SUM   = 2'd2,
    DRAIN   = 2'd3
  } wr_state_e;

  localparam int TRAILER_WORDS = 2;
  localparam int TRAILER_W     = 32;

  function automatic logic [TRAILER_W-1:0] csum_update(
    input logic [TRAILER_W-1:0] csum,
    input logic [TRAILER_W-1:0] word
  );
    return csum ^ word;
  endfunction

  // Trailer word 0 is the payload count, word 1 the XOR of the payload.
  function automatic logic [TRAILER_W-1:0] trailer_word(
    input logic                 idx,
    input logic [TRAILER_W-1:0] count,
    input logic [TRAILER_W-1:0] csum
  );
    return idx ? csum : count;
  endfunction

endpackage

// File: rtl/fifo_frame_writer_if.sv
// rtl/fifo_frame_writer_if.sv - payload stream and FIFO write port of the frame writer
interface fifo_frame_writer_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             s_ready;
  logic             fifo_full;
  logic             fifo_wen;
  logic [WIDTH-1:0] fifo_wdata;

  modport master (
    output s_valid, s_data, s_last, fifo_full,
    input  s_ready, fifo_wen, fifo_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last, fifo_full,
    output s_ready, fifo_wen, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_stage.sv
// rtl/fifo_wr_stage.sv - single hold register in front of the async FIFO write port
module fifo_wr_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             fifo_full_i,
  output logic             free_o,
  output logic             wen_o,
  output logic [WIDTH-1:0] wdata_o
);

  logic             hv_q, hv_d;
  logic [WIDTH-1:0] hd_q, hd_d;

  // A pending word leaves the same cycle full drops, so the slot is reusable at once.
  assign free_o  = ~hv_q | ~fifo_full_i;
  assign wen_o   = hv_q & ~fifo_full_i & ~rst_i;
  assign wdata_o = hd_q;

  always_comb begin
    hv_d = hv_q;
    hd_d = hd_q;
    if (free_o) begin
      hv_d = load_i;
      if (load_i) begin
        hd_d = load_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hv_q <= 1'b0;
      hd_q <= '0;
    end else begin
      hv_q <= hv_d;
      hd_q <= hd_d;
    end
  end

endmodule

// File: rtl/fifo_frame_writer.sv
// rtl/fifo_frame_writer.sv - frames a payload stream as words + count + XOR trailer into the async FIFO
module fifo_frame_writer
  import fifo_frame_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 wclk,
  input  logic                 rst,
  fifo_frame_writer_if.slave   bus,
  output logic [CNT_W-1:0]     frames_done,
  output logic                 trunc
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(MAX_LEN - 1);

  wr_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] csum_q;
  logic             drain_q;
  logic             trunc_q;
  logic [CNT_W-1:0] frames_done_q;

  logic             free;
  logic             acc;
  logic             ready;
  logic             load;
  logic [WIDTH-1:0] load_data;

  assign acc         = bus.s_valid & ready;
  assign bus.s_ready = ready;
  assign frames_done = frames_done_q;
  assign trunc       = trunc_q;

  fifo_wr_stage #(.WIDTH(WIDTH)) u_stage (
    .clk_i       (wclk),
    .rst_i       (rst),
    .load_i      (load),
    .load_data_i (load_data),
    .fifo_full_i (bus.fifo_full),
    .free_o      (free),
    .wen_o       (bus.fifo_wen),
    .wdata_o     (bus.fifo_wdata)
  );

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= PAYLOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAYLOAD: begin
        if (acc && (bus.s_last || count_q == LAST_IDX)) begin
          state_d = T_CNT;
        end
      end
      T_CNT: begin
        if (free) begin
          state_d = T_SUM;
        end
      end
      T_SUM: begin
        if (free) begin
          state_d = drain_q ? DRAIN : PAYLOAD;
        end
      end
      DRAIN: begin
        if (acc && bus.s_last) begin
          state_d = PAYLOAD;
        end
      end
      default: state_d = PAYLOAD;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    load      = 1'b0;
    load_data = bus.s_data;
    case (state_q)
      PAYLOAD: begin
        ready     = free & ~rst;
        load      = acc;
        load_data = bus.s_data;
      end
      T_CNT: begin
        load      = free;
        load_data = count_q;
      end
      T_SUM: begin
        load      = free;
        load_data = csum_q;
      end
      DRAIN: begin
        ready = ~rst;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // Frame bookkeeping; count/csum clear once the checksum word is in the hold register.
  always_ff @(posedge wclk) begin
    if (rst) begin
      count_q       <= '0;
      csum_q        <= '0;
      drain_q       <= 1'b0;
      trunc_q       <= 1'b0;
      frames_done_q <= '0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        PAYLOAD: begin
          if (acc) begin
            count_q <= count_q + 1'b1;
            csum_q  <= csum_q ^ bus.s_data;
            if (!bus.s_last && count_q == LAST_IDX) begin
              trunc_q <= 1'b1;
              drain_q <= 1'b1;
            end
          end
        end
        T_SUM: begin
          if (free) begin
            frames_done_q <= frames_done_q + 1'b1;
            count_q       <= '0;
            csum_q        <= '0;
          end
        end
        DRAIN: begin
          if (acc && bus.s_last) begin
            drain_q <= 1'b0;
          end
        end
        default: begin
          drain_q <= drain_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// tb/tb_fifo_frame_writer.sv - directed self-checking bench for fifo_frame_writer
module tb_fifo_frame_writer;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 2;

  logic             wclk = 1'b0;
  logic             rst  = 1'b1;
  logic [CNT_W-1:0] frames_done;
  logic             trunc;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  int trunc_cnt = 0;
  int stall_cnt = 0;
  logic [7:0] wq[$];

  fifo_frame_writer_if #(.WIDTH(WIDTH)) bus ();

  fifo_frame_writer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .wclk        (wclk),
    .rst         (rst),
    .bus         (bus),
    .frames_done (frames_done),
    .trunc       (trunc)
  );

  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (bus.fifo_wen === 1'b1) wq.push_back(bus.fifo_wdata);
    if (trunc === 1'b1) trunc_cnt++;
    if (!rst && !bus.fifo_full && bus.s_valid && bus.s_ready === 1'b0) stall_cnt++;
  end

  task automatic send_word(input logic [7:0] d, input logic last);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    forever begin
      @(negedge wclk);
      if (bus.s_ready === 1'b1) begin
        @(posedge wclk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout data=%h s_ready=%b required 1", d, bus.s_ready);
        break;
      end
      @(posedge wclk); #1;
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) begin @(posedge wclk); #1; end
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b1; bus.s_data = 8'h99; bus.s_last = 1'b0; bus.fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge wclk); #1; end
    @(negedge wclk);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
    checks++; if (bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus.fifo_wen); end
    @(posedge wclk); #1;
    rst = 1'b0; bus.s_valid = 1'b0;
    @(negedge wclk);
    checks++; if (bus.fifo_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", bus.fifo_wdata); end
    checks++; if (frames_done !== 2'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", frames_done); end
    checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL reset_trunc got=%b exp=0", trunc); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready got=%b exp=1", bus.s_ready); end
    @(posedge wclk); #1;
    exp_frames = 0;
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp[$] = '{8'hA5, 8'h0F, 8'h02, 8'hAA};
    wq.delete(); trunc_cnt = 0;
    send_word(8'hA5, 1'b0);
    send_word(8'h0F, 1'b1);
    idle(6);
    exp_frames++;
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL basic_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL basic_frames got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
    checks++; if (trunc_cnt !== 0) begin errors++; $display("FAIL basic_trunc got=%0d exp=0", trunc_cnt); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp[$] = '{8'h3C, 8'h01, 8'h3C};
    wq.delete();
    send_word(8'h3C, 1'b1);
    idle(6);
    exp_frames++;
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL single_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL single_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL single_frames got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$] = '{8'h11, 8'h22, 8'h33, 8'h03, 8'h00};
    wq.delete();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    bus.fifo_full = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h33; bus.s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready c%0d got=%b exp=0", c, bus.s_ready); end
      checks++; if (bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL bp_wen c%0d got=%b exp=0", c, bus.fifo_wen); end
      checks++; if (bus.fifo_wdata !== 8'h22) begin errors++; $display("FAIL bp_wdata c%0d got=%h exp=22", c, bus.fifo_wdata); end
      @(posedge wclk); #1;
    end
    bus.fifo_full = 1'b0;
    send_word(8'h33, 1'b1);
    idle(6);
    exp_frames++;
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL bp_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL bp_frames got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  task automatic test_truncation();
    logic [7:0] exp[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h07, 8'h01, 8'h07};
    wq.delete(); trunc_cnt = 0;
    for (int i = 1; i <= 6; i++) send_word(8'(i), i == 6);
    idle(6);
    exp_frames++;
    checks++; if (trunc_cnt !== 1) begin errors++; $display("FAIL trunc_pulses got=%0d exp=1", trunc_cnt); end
    send_word(8'h07, 1'b1);
    idle(6);
    exp_frames++;
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL trunc_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL trunc_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL trunc_frames got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  task automatic test_max_len_last();
    logic [7:0] exp[$] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h04, 8'h40, 8'h55, 8'h01, 8'h55};
    wq.delete(); trunc_cnt = 0;
    send_word(8'h10, 1'b0);
    send_word(8'h20, 1'b0);
    send_word(8'h30, 1'b0);
    send_word(8'h40, 1'b1);
    idle(6);
    send_word(8'h55, 1'b1);
    idle(6);
    exp_frames += 2;
    checks++; if (trunc_cnt !== 0) begin errors++; $display("FAIL maxlast_trunc got=%0d exp=0", trunc_cnt); end
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL maxlast_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL maxlast_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL maxlast_frames got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$] = '{8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h01, 8'h03,
                           8'h04, 8'h05, 8'h06, 8'h03, 8'h07};
    wq.delete(); stall_cnt = 0;
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b1);
    send_word(8'h03, 1'b1);
    send_word(8'h04, 1'b0);
    send_word(8'h05, 1'b0);
    send_word(8'h06, 1'b1);
    idle(6);
    exp_frames += 3;
    checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL b2b_stalls got=%0d exp=4", stall_cnt); end
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL b2b_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL b2b_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL b2b_frames got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp[$] = '{8'h0A, 8'h0C, 8'h01, 8'h0C};
    wq.delete();
    send_word(8'h0A, 1'b0);
    send_word(8'h0B, 1'b0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge wclk); #1;
    rst = 1'b0;
    idle(6);
    exp_frames = 0;
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL rstmid_writes got=%0d exp=1", wq.size()); end
    checks++; if (frames_done !== 2'd0) begin errors++; $display("FAIL rstmid_frames got=%0d exp=0", frames_done); end
    send_word(8'h0C, 1'b1);
    idle(6);
    exp_frames++;
    checks++; if (wq.size() !== exp.size()) begin errors++; $display("FAIL rstmid_len got=%0d exp=%0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL rstmid_word%0d got=%h exp=%h", i, wq[i], exp[i]); end
    end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL rstmid_frames_after got=%0d exp=%0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0; bus.fifo_full = 1'b0;
    test_reset();
    test_basic_frame();
    test_single_word();
    test_backpressure();
    test_truncation();
    test_max_len_last();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
